// File: rtl/uart_mem_loader_pkg.sv
// Shared command/response codes, FSM encodings and word-assembly helpers
// for the UART memory loader.
package uart_mem_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_READ   = 3'd4,
    S_RDWAIT = 3'd5,
    S_SEND   = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Little-endian assembly: each new byte lands in the top lane.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_mem_loader_rx.sv
// Serial receiver for the loader: input synchronizer, mid-bit sampler and
// stop-bit check; emits each good byte with a one-cycle valid.
module uart_loader_rx
  import uart_mem_loader_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  rx_state_t       state_r;
  rx_state_t       state_nx_s;
  logic            sync1_r;
  logic            sync2_r;
  logic            prev_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_r;
  logic [7:0]      shift_r;
  logic [7:0]      data_r;
  logic            valid_r;
  logic            fall_s;
  logic            tick_s;
  logic            frame_ok_s;

  // Two-flop synchronizer plus edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Sample-point decode for the current state
  always_comb begin
    fall_s     = prev_r & ~sync2_r;
    tick_s     = 1'b0;
    frame_ok_s = 1'b0;
    case (state_r)
      RX_START: tick_s = (cnt_r == HALF_M1);
      RX_DATA:  tick_s = (cnt_r == DIV_M1);
      RX_STOP: begin
        tick_s     = (cnt_r == DIV_M1);
        frame_ok_s = (cnt_r == DIV_M1) && sync2_r;
      end
      default:  tick_s = 1'b0;
    endcase
  end

  // Receiver next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (fall_s) state_nx_s = RX_START;
        else        state_nx_s = RX_IDLE;
      end
      RX_START: begin
        if (tick_s) state_nx_s = sync2_r ? RX_IDLE : RX_DATA;
        else        state_nx_s = RX_START;
      end
      RX_DATA: begin
        if (tick_s && (bit_r == 3'd7)) state_nx_s = RX_STOP;
        else                           state_nx_s = RX_DATA;
      end
      RX_STOP: begin
        if (tick_s) state_nx_s = RX_IDLE;
        else        state_nx_s = RX_STOP;
      end
      default: state_nx_s = RX_IDLE;
    endcase
  end

  // Bit timing, shift register and byte output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      valid_r <= frame_ok_s;
      if (frame_ok_s) data_r <= shift_r;
      if (state_r == RX_IDLE || tick_s) cnt_r <= '0;
      else                              cnt_r <= cnt_r + CW'(1);
      if (state_r == RX_START) bit_r <= 3'd0;
      if (state_r == RX_DATA && tick_s) begin
        shift_r <= {sync2_r, shift_r[7:1]};
        bit_r   <= bit_r + 3'd1;
      end
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/uart_mem_loader.sv
// Host-driven memory loader: UART command protocol (W/R/G) that writes and
// reads a word-wide RAM while holding the CPU in reset until 'G'.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int CLOCK_RATE = 24_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        cpu_hold,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic [7:0]    rx_data_s;
  logic          rx_valid_s;
  logic          hold_valid_r;
  logic [7:0]    hold_data_r;

  state_t        state_r;
  state_t        state_nx_s;
  logic [1:0]    cnt_r;
  logic          is_write_r;
  logic          allowed_r;
  logic [31:0]   addr_r;
  logic [31:0]   data_r;
  logic [31:0]   rd_word_r;
  logic [7:0]    resp_r;
  logic          cpu_hold_r;
  logic          mem_write_r;
  logic [3:0]    mem_wmask_r;
  logic [31:0]   mem_wdata_r;
  logic [31:0]   mem_addr_r;

  logic          consume_s;
  logic          last_s;
  logic          tx_start_s;
  logic [7:0]    tx_byte_s;
  logic          tx_ready_s;
  logic          tx_load_s;
  logic [31:0]   addr_nx_s;
  logic [31:0]   data_nx_s;

  logic          tx_busy_r;
  logic          uart_tx_r;
  logic [8:0]    tx_shift_r;
  logic [3:0]    tx_bit_r;
  logic [CW-1:0] tx_cnt_r;

  uart_loader_rx #(.DIV(DIV)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .data    (rx_data_s),
    .valid   (rx_valid_s)
  );

  // One-byte holding register; a newer byte overwrites an unconsumed one
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
    end else if (rx_valid_s) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= rx_data_s;
    end else if (consume_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  // Command FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Command FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (consume_s) begin
          if (hold_data_r == CMD_WRITE || hold_data_r == CMD_READ) state_nx_s = S_ADDR;
          else                                                    state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ADDR: begin
        if (consume_s && last_s) begin
          if (is_write_r)     state_nx_s = S_DATA;
          else if (allowed_r) state_nx_s = S_READ;
          else                state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_ADDR;
        end
      end
      S_DATA: begin
        if (consume_s && last_s) state_nx_s = allowed_r ? S_WRITE : S_RESP;
        else                     state_nx_s = S_DATA;
      end
      S_WRITE:  state_nx_s = S_RESP;
      S_READ:   state_nx_s = S_RDWAIT;
      S_RDWAIT: state_nx_s = S_SEND;
      S_SEND: begin
        if (tx_ready_s && last_s) state_nx_s = S_IDLE;
        else                      state_nx_s = S_SEND;
      end
      S_RESP: begin
        if (tx_ready_s) state_nx_s = S_IDLE;
        else            state_nx_s = S_RESP;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Command FSM outputs: byte consumption and transmit requests
  always_comb begin
    consume_s  = 1'b0;
    tx_start_s = 1'b0;
    tx_byte_s  = 8'h00;
    last_s     = (cnt_r == 2'd3);
    addr_nx_s  = shift_in_byte(addr_r, hold_data_r);
    data_nx_s  = shift_in_byte(data_r, hold_data_r);
    case (state_r)
      S_IDLE, S_ADDR, S_DATA: consume_s = hold_valid_r;
      S_SEND: begin
        tx_start_s = 1'b1;
        tx_byte_s  = rd_word_r[7:0];
      end
      S_RESP: begin
        tx_start_s = 1'b1;
        tx_byte_s  = resp_r;
      end
      default: consume_s = 1'b0;
    endcase
  end

  // Command datapath, CPU hold and registered memory-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= 2'd0;
      is_write_r  <= 1'b0;
      allowed_r   <= 1'b0;
      addr_r      <= 32'h0000_0000;
      data_r      <= 32'h0000_0000;
      rd_word_r   <= 32'h0000_0000;
      resp_r      <= 8'h00;
      cpu_hold_r  <= 1'b1;
      mem_write_r <= 1'b0;
      mem_wmask_r <= 4'h0;
      mem_wdata_r <= 32'h0000_0000;
      mem_addr_r  <= 32'h0000_0000;
    end else begin
      mem_write_r <= (state_nx_s == S_WRITE);
      mem_wmask_r <= {4{state_nx_s == S_WRITE}};
      case (state_r)
        S_IDLE: begin
          if (consume_s) begin
            cnt_r      <= 2'd0;
            is_write_r <= (hold_data_r == CMD_WRITE);
            allowed_r  <= cpu_hold_r;
            if (hold_data_r == CMD_GO) begin
              cpu_hold_r <= 1'b0;
              resp_r     <= RSP_ACK;
            end else begin
              resp_r     <= RSP_NAK;
            end
          end
        end
        S_ADDR: begin
          if (consume_s) begin
            addr_r <= addr_nx_s;
            cnt_r  <= cnt_r + 2'd1;
            if (last_s && allowed_r) mem_addr_r <= word_align(addr_nx_s);
          end
        end
        S_DATA: begin
          if (consume_s) begin
            data_r <= data_nx_s;
            cnt_r  <= cnt_r + 2'd1;
            if (last_s && allowed_r) mem_wdata_r <= data_nx_s;
          end
        end
        S_WRITE:  resp_r <= RSP_ACK;
        S_RDWAIT: begin
          rd_word_r <= mem_rdata;
          cnt_r     <= 2'd0;
        end
        S_SEND: begin
          if (tx_load_s) begin
            rd_word_r <= {8'h00, rd_word_r[31:8]};
            cnt_r     <= cnt_r + 2'd1;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // A new byte may start on the last stop-bit cycle so bytes run back to back
  assign tx_ready_s = !tx_busy_r || ((tx_cnt_r == DIV_M1) && (tx_bit_r == 4'd9));
  assign tx_load_s  = tx_start_s && tx_ready_s;

  // Transmitter: start, 8 data bits LSB first, stop, DIV cycles each
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_r  <= 1'b0;
      uart_tx_r  <= 1'b1;
      tx_shift_r <= 9'h1FF;
      tx_bit_r   <= 4'd0;
      tx_cnt_r   <= '0;
    end else if (tx_load_s) begin
      tx_busy_r  <= 1'b1;
      uart_tx_r  <= 1'b0;
      tx_shift_r <= {1'b1, tx_byte_s};
      tx_bit_r   <= 4'd0;
      tx_cnt_r   <= '0;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == DIV_M1) begin
        tx_cnt_r <= '0;
        if (tx_bit_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          uart_tx_r <= 1'b1;
        end else begin
          uart_tx_r  <= tx_shift_r[0];
          tx_shift_r <= {1'b1, tx_shift_r[8:1]};
          tx_bit_r   <= tx_bit_r + 4'd1;
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + CW'(1);
      end
    end
  end

  assign uart_tx   = uart_tx_r;
  assign cpu_hold  = cpu_hold_r;
  assign mem_write = mem_write_r;
  assign mem_wmask = mem_wmask_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader at DIV=8: directed host frames, a
// UART decoder and a write-port monitor checking against queued expectations.
module tb_uart_mem_loader;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        cpu_hold;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [7:0]  exp_tx_q[$];
  logic [63:0] exp_wr_q[$];

  uart_mem_loader #(.CLOCK_RATE(8), .BAUD_RATE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .cpu_hold  (cpu_hold),
    .mem_write (mem_write),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: fixed word at 0x100, zero elsewhere
  always @(posedge clk) begin
    mem_rdata <= (mem_addr == 32'h0000_0100) ? 32'hDEAD_BEEF : 32'h0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (!rst && mem_write === 1'b1) begin
      wr_count++;
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_wr_q.pop_front();
        check("wr_addr", {32'h0, mem_addr}, {32'h0, e[63:32]});
        check("wr_data", {32'h0, mem_wdata}, {32'h0, e[31:0]});
        check("wr_mask", {60'h0, mem_wmask}, 64'hF);
      end
    end
  end

  // UART transmit decoder
  initial begin
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge uart_tx);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      stop = uart_tx;
      check("tx_stop", {63'h0, stop}, 64'h1);
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx actual=%0h required none", b);
      end else begin
        check("tx_byte", {56'h0, b}, {56'h0, exp_tx_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data, input bit with_data);
    send_byte(cmd, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
    if (with_data) begin
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || exp_wr_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_tx_q.size() + exp_wr_q.size()), 64'h0);
    repeat (12 * DIV) @(negedge clk);
  endtask

  initial begin
    int w0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", {63'h0, uart_tx}, 64'h1);
    check("rst_cpu_hold", {63'h0, cpu_hold}, 64'h1);
    check("rst_mem_write", {63'h0, mem_write}, 64'h0);
    check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    check("rst_mem_wmask", {60'h0, mem_wmask}, 64'h0);
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);

    // Write DEADBEEF to 0x100
    w0 = wr_count;
    exp_wr_q.push_back({32'h0000_0100, 32'hDEAD_BEEF});
    exp_tx_q.push_back(8'h06);
    send_frame(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    drain("drain_write");
    check("write_pulses", 64'(wr_count - w0), 64'h1);

    // Read back from 0x100
    w0 = wr_count;
    exp_tx_q.push_back(8'hEF); exp_tx_q.push_back(8'hBE);
    exp_tx_q.push_back(8'hAD); exp_tx_q.push_back(8'hDE);
    send_frame(8'h52, 32'h0000_0100, 32'h0, 1'b0);
    drain("drain_read");
    check("read_no_write", 64'(wr_count - w0), 64'h0);

    // Framing error dropped, following read answered normally
    w0 = wr_count;
    send_byte(8'h57, 1'b0);
    exp_tx_q.push_back(8'hEF); exp_tx_q.push_back(8'hBE);
    exp_tx_q.push_back(8'hAD); exp_tx_q.push_back(8'hDE);
    send_frame(8'h52, 32'h0000_0100, 32'h0, 1'b0);
    drain("drain_framing");
    check("framing_no_write", 64'(wr_count - w0), 64'h0);

    // Reset after three address bytes, then a fresh unaligned write
    w0 = wr_count;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_cpu_hold", {63'h0, cpu_hold}, 64'h1);
    check("midrst_uart_tx", {63'h0, uart_tx}, 64'h1);
    check("midrst_mem_addr", {32'h0, mem_addr}, 64'h0);
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    check("midrst_no_write", 64'(wr_count - w0), 64'h0);
    exp_wr_q.push_back({32'h0000_0204, 32'h1234_5678});
    exp_tx_q.push_back(8'h06);
    send_frame(8'h57, 32'h0000_0206, 32'h1234_5678, 1'b1);
    drain("drain_rewrite");
    check("rewrite_pulses", 64'(wr_count - w0), 64'h1);

    // Release the CPU; afterwards memory commands are refused
    exp_tx_q.push_back(8'h06);
    send_byte(8'h47, 1'b1);
    drain("drain_go");
    check("go_cpu_hold", {63'h0, cpu_hold}, 64'h0);

    w0 = wr_count;
    exp_tx_q.push_back(8'h15);
    send_frame(8'h57, 32'h0000_0100, 32'hCAFE_F00D, 1'b1);
    drain("drain_locked_write");
    check("locked_no_write", 64'(wr_count - w0), 64'h0);
    check("locked_wdata_held", {32'h0, mem_wdata}, {32'h0, 32'h1234_5678});

    exp_tx_q.push_back(8'h15);
    send_frame(8'h52, 32'h0000_0100, 32'h0, 1'b0);
    drain("drain_locked_read");

    exp_tx_q.push_back(8'h15);
    send_byte(8'h33, 1'b1);
    drain("drain_unknown");

    exp_tx_q.push_back(8'h06);
    send_byte(8'h47, 1'b1);
    drain("drain_go_again");
    check("go_again_cpu_hold", {63'h0, cpu_hold}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter CLOCK_RATE, default 24_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, UART bit rate; DIV = CLOCK_RATE/BAUD_RATE (integer division), DIV >= 4.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 uart_rx  input  1  host serial in, 8N1, idle high, asynchronous to clk.
REQ-006 uart_tx  output  1  host serial out, 8N1, idle high.
REQ-007 cpu_hold  output  1  high keeps the CPU pipeline in reset.
REQ-008 mem_write  output  1  one-cycle word write strobe.
REQ-009 mem_wmask  output  4  byte enables; always 4'hF when mem_write=1, else 0.
REQ-010 mem_wdata  output  32  write data.
REQ-011 mem_addr  output  32  byte address, bits [1:0] forced 0.
REQ-012 mem_rdata  input  32  read data, valid exactly one cycle after mem_addr is presented (synchronous RAM).

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-014 RX: a falling edge in idle starts a frame; start bit re-sampled at DIV/2 (low, else abort to idle); data bits LSB first sampled every DIV cycles; stop bit sampled DIV later.
REQ-015 Stop bit sampled 0 = framing error; byte SHALL be dropped with no response and the command FSM left unchanged.
REQ-016 TX: start bit, 8 data bits LSB first, stop bit, each exactly DIV cycles; tx_busy high until stop bit ends; back-to-back bytes with no idle gap.
REQ-017 Command FSM states: IDLE, ADDR, DATA, WRITE, READ, RDWAIT, SEND, RESP.
REQ-018 IDLE: byte 0x57 'W' -> ADDR (write); 0x52 'R' -> ADDR (read); 0x47 'G' -> RESP with 0x06 and cpu_hold cleared; any other byte -> RESP with 0x15.
REQ-019 ADDR collects 4 bytes little-endian; 'W' -> DATA, 'R' -> READ.
REQ-020 DATA collects 4 bytes little-endian -> WRITE.
REQ-021 WRITE: mem_write=1, mem_wmask=4'hF for exactly one cycle -> RESP with 0x06.
REQ-022 READ drives mem_addr for one cycle; RDWAIT captures mem_rdata on the next cycle -> SEND.
REQ-023 SEND transmits the captured word as 4 bytes little-endian, then -> IDLE (no extra ack byte).
REQ-024 RESP transmits one byte, then -> IDLE.
REQ-025 'W' or 'R' received while cpu_hold=0: payload bytes still consumed, no memory access, response 0x15.
REQ-026 'G' while cpu_hold=0: responds 0x06, no other effect.
REQ-027 cpu_hold falls in the same cycle the 'G' byte is accepted; it never rises again except by rst.
REQ-028 A byte received while TX is busy SHALL be buffered (one-byte holding register); a further byte arriving before the buffer drains overwrites it (host must not pipeline).
REQ-029 mem_addr, mem_wdata hold their last value when idle; mem_write=0 outside WRITE.

Reset
REQ-030 rst=1 SHALL force: FSM IDLE, RX/TX idle, uart_tx=1, cpu_hold=1, mem_write=0, mem_wmask=0, mem_addr=0, mem_wdata=0, holding buffer empty, counters 0.
REQ-031 rst mid-frame or mid-transmit SHALL abort immediately; uart_tx returns high the following cycle.

Structure
REQ-032 Command codes (0x57, 0x52, 0x47), response codes (0x06, 0x15) and FSM state encoding SHALL live in a shared package.
REQ-033 The serial receiver (synchronizer, sampler, framing check) SHALL be one sub-module, uart_loader_rx, with outputs data[7:0] and a one-cycle valid; TX and FSM stay in uart_mem_loader.

Verification (CLOCK_RATE=8, BAUD_RATE=1, DIV=8)
REQ-034 Assert rst 2 cycles -> uart_tx=1, cpu_hold=1, mem_write=0, mem_addr=0.
REQ-035 Send 57 00 01 00 00 EF BE AD DE -> exactly one mem_write pulse, mem_addr=0x00000100, mem_wdata=0xDEADBEEF, mem_wmask=F; uart_tx returns 0x06.
REQ-036 Memory model returns 0xDEADBEEF at 0x100; send 52 00 01 00 00 -> uart_tx emits EF BE AD DE, no mem_write.
REQ-037 Send 47 -> cpu_hold=0, tx 0x06; then 57 + 8 payload bytes -> tx 0x15, no mem_write pulse.
REQ-038 Send 0x57 with stop bit 0 -> no tx activity; following valid 'R' frame answered normally.
REQ-039 Pulse rst after 3 'W' address bytes -> cpu_hold=1, no mem_write; a fresh complete 'W' frame then writes correctly and acks 0x06.
